// File: rtl/system_join_ctrl.sv
// -----------------------------------------------------------------------------
// system_join_ctrl
//
// Purpose:
//   Joins a node into a system tree over a flit link. The sequence is:
//     1. Request a parent from a neighbour.
//     2. Wait for the parent ack, which carries the parent id and the global id.
//     3. Send a join request tagged with a random child id.
//     4. Wait for the matching join ack, which assigns the node id.
//   If a wait state runs out of time, the controller retries from step 1.
//   After the last retry times out, it stops in FAILED. A received S_RESET
//   flit returns the block to IDLE from any state.
//
// Optional feature (compile-time macro SYSTEM_JOIN_HEARTBEAT_EN):
//   When defined, the JOINED state sends an S_HEARTBEAT flit every
//   HEARTBEAT_PERIOD cycles. When undefined, there is no heartbeat logic.
//
// Parameters:
//   TIMEOUT_CYCLES    cycles spent in a wait state before a retry
//   MAX_RETRY         retries allowed after the first attempt
//   HEARTBEAT_PERIOD  heartbeat interval (used only with the macro)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle request to begin joining
//   rand_id[7:0]               random child id, sampled on entry to SEND_JREQ
//   tx_valid/tx_ready          outbound flit handshake
//   tx_header[7:0]             outbound flit header
//   tx_payload[63:0]           outbound flit payload
//   rx_valid/rx_ready          inbound flit handshake (rx_ready is always 1)
//   rx_header[7:0]             inbound flit header
//   rx_payload[63:0]           inbound flit payload
//   busy, joined, failed       status flags
//   node_id, parent_id, global_id   ids learned during the join
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module system_join_ctrl #(
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int MAX_RETRY        = 3,
  parameter int HEARTBEAT_PERIOD = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rand_id,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_header,
  output logic [63:0] tx_payload,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_header,
  input  logic [63:0] rx_payload,
  output logic        busy,
  output logic        joined,
  output logic        failed,
  output logic [7:0]  node_id,
  output logic [7:0]  parent_id,
  output logic [7:0]  global_id
);

  // Flit header codes.
  localparam logic [7:0] S_NOPE       = 8'd0;
  localparam logic [7:0] S_HEARTBEAT  = 8'd1;
  localparam logic [7:0] S_RESET      = 8'd2;
  localparam logic [7:0] S_PARENT_REQ = 8'd3;
  localparam logic [7:0] S_PARENT_ACK = 8'd4;
  localparam logic [7:0] S_JOIN_REQ   = 8'd5;
  localparam logic [7:0] S_JOIN_ACK   = 8'd6;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_PREQ = 3'd1,
    ST_WAIT_PACK = 3'd2,
    ST_SEND_JREQ = 3'd3,
    ST_WAIT_JACK = 3'd4,
    ST_JOINED    = 3'd5,
    ST_FAILED    = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [RW-1:0] r_retry, w_retry_nxt;
  logic [7:0]    r_rnd_q, w_rnd_nxt;
  logic [7:0]    r_node_id, w_node_nxt;
  logic [7:0]    r_parent_id, w_parent_nxt;
  logic [7:0]    r_global_id, w_global_nxt;
  logic          r_joined, w_joined_nxt;
  logic          r_failed, w_failed_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_tx_valid, w_tx_valid_nxt;
  logic [7:0]    r_tx_header, w_tx_header_nxt;
  logic [63:0]   r_tx_payload, w_tx_payload_nxt;
  logic          w_hb_pend_nxt;

`ifdef SYSTEM_JOIN_HEARTBEAT_EN
  localparam int HW = (HEARTBEAT_PERIOD > 1) ? $clog2(HEARTBEAT_PERIOD) : 1;
  localparam logic [HW-1:0] HMAX = HW'(HEARTBEAT_PERIOD - 1);
  logic [HW-1:0] r_hb_cnt, w_hb_cnt_nxt;
  logic          r_hb_pend;
`endif

  logic w_tx_hs, w_tx_stall, w_rx_reset, w_pack_hit, w_jack_hit, w_timeout;
  logic w_unused_rx;

  assign w_tx_hs     = r_tx_valid & tx_ready;
  assign w_tx_stall  = r_tx_valid & ~tx_ready;
  assign w_rx_reset  = rx_valid & (rx_header == S_RESET);
  assign w_pack_hit  = rx_valid & (rx_header == S_PARENT_ACK);
  // A join ack counts only if it echoes this node's random id and chosen parent.
  assign w_jack_hit  = rx_valid & (rx_header == S_JOIN_ACK) &
                       (rx_payload[63:56] == r_rnd_q) &
                       (rx_payload[55:48] == r_parent_id);
  assign w_timeout   = (r_timer == TMAX);
  assign w_unused_rx = ^rx_payload[39:0];

  // Next-state, learned-id and registered-output computation.
  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_retry_nxt      = r_retry;
    w_rnd_nxt        = r_rnd_q;
    w_node_nxt       = r_node_id;
    w_parent_nxt     = r_parent_id;
    w_global_nxt     = r_global_id;
    w_joined_nxt     = r_joined;
    w_failed_nxt     = r_failed;
    w_hb_pend_nxt    = 1'b0;
    w_busy_nxt       = 1'b0;
    w_tx_valid_nxt   = 1'b0;
    w_tx_header_nxt  = S_NOPE;
    w_tx_payload_nxt = 64'h0;
`ifdef SYSTEM_JOIN_HEARTBEAT_EN
    w_hb_cnt_nxt     = '0;
`endif

    case (r_state)
      ST_IDLE, ST_FAILED: begin
        if (start) begin
          w_state_nxt  = ST_SEND_PREQ;
          w_retry_nxt  = '0;
          w_failed_nxt = 1'b0;
        end else begin
          w_state_nxt  = r_state;
        end
      end
      ST_SEND_PREQ: begin
        if (w_tx_hs) begin
          w_state_nxt = ST_WAIT_PACK;
          w_timer_nxt = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_WAIT_PACK: begin
        if (w_pack_hit) begin
          w_parent_nxt = rx_payload[63:56];
          w_global_nxt = rx_payload[47:40];
          w_rnd_nxt    = rand_id;
          w_timer_nxt  = '0;
          w_state_nxt  = ST_SEND_JREQ;
        end else if (w_timeout) begin
          if (r_retry < RMAX) begin
            w_retry_nxt = r_retry + RW'(1);
            w_timer_nxt = '0;
            w_state_nxt = ST_SEND_PREQ;
          end else begin
            w_failed_nxt = 1'b1;
            w_state_nxt  = ST_FAILED;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_SEND_JREQ: begin
        if (w_tx_hs) begin
          w_state_nxt = ST_WAIT_JACK;
          w_timer_nxt = '0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_WAIT_JACK: begin
        // A matching ack takes priority over a timeout in the same cycle.
        if (w_jack_hit) begin
          w_node_nxt   = rx_payload[47:40];
          w_joined_nxt = 1'b1;
          w_state_nxt  = ST_JOINED;
        end else if (w_timeout) begin
          if (r_retry < RMAX) begin
            w_retry_nxt = r_retry + RW'(1);
            w_timer_nxt = '0;
            w_state_nxt = ST_SEND_PREQ;
          end else begin
            w_failed_nxt = 1'b1;
            w_state_nxt  = ST_FAILED;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_JOINED: begin
`ifdef SYSTEM_JOIN_HEARTBEAT_EN
        // The period counter freezes while a heartbeat is stalled on tx_ready.
        if (w_tx_stall) begin
          w_hb_cnt_nxt  = r_hb_cnt;
          w_hb_pend_nxt = r_hb_pend;
        end else if (r_hb_cnt == HMAX) begin
          w_hb_cnt_nxt  = '0;
          w_hb_pend_nxt = 1'b1;
        end else begin
          w_hb_cnt_nxt  = r_hb_cnt + HW'(1);
          w_hb_pend_nxt = 1'b0;
        end
`else
        w_hb_pend_nxt = 1'b0;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // An inbound S_RESET overrides everything above.
    if (w_rx_reset) begin
      w_state_nxt   = ST_IDLE;
      w_timer_nxt   = '0;
      w_retry_nxt   = '0;
      w_rnd_nxt     = 8'h0;
      w_node_nxt    = 8'h0;
      w_parent_nxt  = 8'h0;
      w_global_nxt  = 8'h0;
      w_joined_nxt  = 1'b0;
      w_failed_nxt  = 1'b0;
      w_hb_pend_nxt = 1'b0;
`ifdef SYSTEM_JOIN_HEARTBEAT_EN
      w_hb_cnt_nxt  = '0;
`endif
    end else begin
      w_state_nxt = w_state_nxt;
    end

    // The outbound flit is a function of the next state and the next ids.
    // It therefore stays constant for as long as the state is stalled.
    case (w_state_nxt)
      ST_SEND_PREQ: begin
        w_busy_nxt       = 1'b1;
        w_tx_valid_nxt   = 1'b1;
        w_tx_header_nxt  = S_PARENT_REQ;
        w_tx_payload_nxt = 64'h0;
      end
      ST_SEND_JREQ: begin
        w_busy_nxt       = 1'b1;
        w_tx_valid_nxt   = 1'b1;
        w_tx_header_nxt  = S_JOIN_REQ;
        w_tx_payload_nxt = {w_rnd_nxt, w_parent_nxt, 48'h0};
      end
      ST_WAIT_PACK, ST_WAIT_JACK: begin
        w_busy_nxt       = 1'b1;
      end
      ST_JOINED: begin
        if (w_hb_pend_nxt) begin
          w_tx_valid_nxt   = 1'b1;
          w_tx_header_nxt  = S_HEARTBEAT;
          w_tx_payload_nxt = {w_node_nxt, 56'h0};
        end else begin
          w_tx_valid_nxt   = 1'b0;
        end
      end
      default: begin
        w_busy_nxt       = 1'b0;
      end
    endcase
  end

  // State, id and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_retry      <= '0;
      r_rnd_q      <= 8'h0;
      r_node_id    <= 8'h0;
      r_parent_id  <= 8'h0;
      r_global_id  <= 8'h0;
      r_joined     <= 1'b0;
      r_failed     <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_header  <= S_NOPE;
      r_tx_payload <= 64'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_retry      <= w_retry_nxt;
      r_rnd_q      <= w_rnd_nxt;
      r_node_id    <= w_node_nxt;
      r_parent_id  <= w_parent_nxt;
      r_global_id  <= w_global_nxt;
      r_joined     <= w_joined_nxt;
      r_failed     <= w_failed_nxt;
      r_busy       <= w_busy_nxt;
      r_tx_valid   <= w_tx_valid_nxt;
      r_tx_header  <= w_tx_header_nxt;
      r_tx_payload <= w_tx_payload_nxt;
    end
  end

`ifdef SYSTEM_JOIN_HEARTBEAT_EN
  // Heartbeat period counter and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hb_cnt  <= '0;
      r_hb_pend <= 1'b0;
    end else begin
      r_hb_cnt  <= w_hb_cnt_nxt;
      r_hb_pend <= w_hb_pend_nxt;
    end
  end
`endif

  assign rx_ready   = 1'b1;
  assign tx_valid   = r_tx_valid;
  assign tx_header  = r_tx_header;
  assign tx_payload = r_tx_payload;
  assign busy       = r_busy;
  assign joined     = r_joined;
  assign failed     = r_failed;
  assign node_id    = r_node_id;
  assign parent_id  = r_parent_id;
  assign global_id  = r_global_id;

endmodule

// File: tb/tb_system_join_ctrl.sv
// -----------------------------------------------------------------------------
// tb_system_join_ctrl
//
// Directed bench for system_join_ctrl.
//
// Every outbound flit the bench expects is queued when the stimulus that
// causes it is issued. A monitor on the falling clock edge pops the queue on
// each tx handshake and compares the popped entry against the flit. Status
// and id outputs are checked inline, 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_system_join_ctrl;

  localparam int TO = 8;
  localparam int MR = 2;
  localparam int HB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rand_id = 8'h0;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_header = 8'h0;
  logic [63:0] rx_payload = 64'h0;
  logic        tx_valid, rx_ready, busy, joined, failed;
  logic [7:0]  tx_header, node_id, parent_id, global_id;
  logic [63:0] tx_payload;

  typedef struct {
    logic [7:0]  h;
    logic [63:0] p;
  } flit_t;

  flit_t sb[$];
  int    n_checks = 0;
  int    n_fail = 0;

  system_join_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRY(MR),
    .HEARTBEAT_PERIOD(HB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rand_id(rand_id),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_header(tx_header),
    .tx_payload(tx_payload), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_header(rx_header), .rx_payload(rx_payload), .busy(busy),
    .joined(joined), .failed(failed), .node_id(node_id),
    .parent_id(parent_id), .global_id(global_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] h, input logic [63:0] p);
    flit_t f;
    f.h = h;
    f.p = p;
    sb.push_back(f);
  endtask

  task automatic send_rx(input logic [7:0] h, input logic [63:0] p);
    rx_valid = 1'b1;
    rx_header = h;
    rx_payload = p;
    tick(1);
    rx_valid = 1'b0;
    rx_header = 8'h0;
    rx_payload = 64'h0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, {63'h0, tx_valid}, 64'h0);
    check({tag, "_tx_header"}, {56'h0, tx_header}, 64'h0);
    check({tag, "_tx_payload"}, tx_payload, 64'h0);
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
    check({tag, "_joined"}, {63'h0, joined}, 64'h0);
    check({tag, "_failed"}, {63'h0, failed}, 64'h0);
    check({tag, "_ids"}, {40'h0, node_id, parent_id, global_id}, 64'h0);
  endtask

  // Scoreboard monitor: every tx handshake must match the oldest expected flit.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_tx: got hdr 0x%0h payload 0x%0h, expected no flit",
                 tx_header, tx_payload);
      end else begin
        flit_t e;
        e = sb.pop_front();
        check("tx_header", {56'h0, tx_header}, {56'h0, e.h});
        check("tx_payload", tx_payload, e.p);
      end
    end
  end

  // Absolute time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int hb_seen;
    int hb_first;
    int hb_second;

    // Reset state.
    tick(2);
    check_reset_outputs("reset");
    check("rx_ready", {63'h0, rx_ready}, 64'h1);
    rst_n = 1'b1;
    tick(1);

    // Full join sequence with tx_ready held high.
    tx_ready = 1'b1;
    rand_id = 8'hA5;
    push(8'd3, 64'h0);
    pulse_start();
    check("preq_busy", {63'h0, busy}, 64'h1);
    tick(1);
    push(8'd5, 64'hA512_0000_0000_0000);
    send_rx(8'd4, 64'h1200_4000_0000_0000);
    tick(1);
    send_rx(8'd6, 64'hA512_0700_0000_0000);
    check("join_joined", {63'h0, joined}, 64'h1);
    check("join_ids", {40'h0, node_id, parent_id, global_id}, 64'h0712_40);
    check("join_busy", {63'h0, busy}, 64'h0);

    // start while JOINED is ignored.
    pulse_start();
    check("start_ignored_busy", {63'h0, busy}, 64'h0);
    check("start_ignored_joined", {63'h0, joined}, 64'h1);

    // S_RESET from JOINED clears the learned state.
    send_rx(8'd2, 64'h0);
    check_reset_outputs("srst_joined");

    // The PARENT_REQUEST flit is held through 5 stalled cycles.
    tx_ready = 1'b0;
    push(8'd3, 64'h0);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {63'h0, tx_valid}, 64'h1);
      check("stall_header", {56'h0, tx_header}, 64'h3);
      tick(1);
    end
    tx_ready = 1'b1;
    tick(1);
    check("after_hs_valid", {63'h0, tx_valid}, 64'h0);
    check("after_hs_busy", {63'h0, busy}, 64'h1);

    // A mismatching join ack is dropped; only the correct ack completes the join.
    push(8'd5, 64'hA512_0000_0000_0000);
    send_rx(8'd4, 64'h1200_4000_0000_0000);
    tick(1);
    send_rx(8'd6, 64'hA412_0900_0000_0000);
    check("bad_ack_joined", {63'h0, joined}, 64'h0);
    check("bad_ack_node", {56'h0, node_id}, 64'h0);
    check("bad_ack_busy", {63'h0, busy}, 64'h1);
    send_rx(8'd6, 64'hA512_0700_0000_0000);
    check("good_ack_joined", {63'h0, joined}, 64'h1);
    check("good_ack_node", {56'h0, node_id}, 64'h07);

    // Heartbeat behaviour in JOINED.
`ifdef SYSTEM_JOIN_HEARTBEAT_EN
    push(8'd1, 64'h0700_0000_0000_0000);
    push(8'd1, 64'h0700_0000_0000_0000);
`endif
    hb_seen = 0;
    hb_first = 0;
    hb_second = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (tx_valid) begin
        hb_seen++;
        if (hb_seen == 1) hb_first = i;
        if (hb_seen == 2) hb_second = i;
      end
    end
`ifdef SYSTEM_JOIN_HEARTBEAT_EN
    check("hb_count", 64'(hb_seen), 64'd2);
    check("hb_interval", 64'(hb_second - hb_first), 64'(HB));
`else
    check("hb_count", 64'(hb_seen), 64'd0);
`endif

    // S_RESET while in WAIT_JACK.
    send_rx(8'd2, 64'h0);
    push(8'd3, 64'h0);
    push(8'd5, 64'hA512_0000_0000_0000);
    pulse_start();
    tick(1);
    send_rx(8'd4, 64'h1200_4000_0000_0000);
    tick(1);
    check("wait_jack_busy", {63'h0, busy}, 64'h1);
    send_rx(8'd2, 64'h0);
    check_reset_outputs("srst_wait_jack");

    // rst_n asserted while a JOIN_REQUEST is stalled.
    push(8'd3, 64'h0);
    pulse_start();
    tick(1);
    tx_ready = 1'b0;
    send_rx(8'd4, 64'h1200_4000_0000_0000);
    check("jreq_stalled_valid", {63'h0, tx_valid}, 64'h1);
    check("jreq_stalled_header", {56'h0, tx_header}, 64'h5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rstn_jreq");
    tick(1);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    tick(1);
    check_reset_outputs("rstn_release");

    // With no acks, three PARENT_REQUEST attempts each time out, then FAILED.
    push(8'd3, 64'h0);
    push(8'd3, 64'h0);
    push(8'd3, 64'h0);
    pulse_start();
    cyc = 0;
    while (!failed && cyc < 60) begin
      tick(1);
      cyc++;
    end
    check("timeout_cycles_to_fail", 64'(cyc), 64'(3 * (TO + 1)));
    check("failed_flag", {63'h0, failed}, 64'h1);
    check("failed_busy", {63'h0, busy}, 64'h0);

    // start restarts from FAILED.
    push(8'd3, 64'h0);
    pulse_start();
    check("restart_busy", {63'h0, busy}, 64'h1);
    check("restart_failed", {63'h0, failed}, 64'h0);
    tick(1);
    send_rx(8'd2, 64'h0);
    tick(2);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/system_join_ctrl.md
SYSTEM_JOIN_CTRL -- requirements
Module: system_join_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: wait-state cycles before a retry.
REQ-002 Parameter MAX_RETRY, default 3: retries allowed after the first attempt before failure.
REQ-003 Parameter HEARTBEAT_PERIOD, default 4096: cycles between heartbeats, used only with SYSTEM_JOIN_HEARTBEAT_EN.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to begin joining.
REQ-007 rand_id  in  8  random child id, sampled when a join request is built.
REQ-008 tx_valid, tx_ready  out/in  1  outbound system-flit handshake.
REQ-009 tx_header  out  8  system_header_t code; tx_payload  out  64  system_payload_t.
REQ-010 rx_valid  in  1; rx_ready  out  1, tied 1; rx_header  in  8; rx_payload  in  64  inbound system flits.
REQ-011 busy, joined, failed  out  1  status; node_id, parent_id, global_id  out  8  learned ids.

Function
REQ-012 States: IDLE, SEND_PREQ, WAIT_PACK, SEND_JREQ, WAIT_JACK, JOINED, FAILED; busy=1 in SEND_*/WAIT_*.
REQ-013 start is accepted in IDLE or FAILED only -> SEND_PREQ, retry count=0, failed=0; ignored elsewhere.
REQ-014 SEND_PREQ: tx_valid=1, header=S_PARENT_REQUEST_FROM_NEIGHBOR (3), payload=0; on tx_valid&tx_ready -> WAIT_PACK, timer=0.
REQ-015 WAIT_PACK: rx_valid with header S_PARENT_ACK_FROM_NEIGHBOR (4) latches parent_id=payload[63:56], global_id=payload[47:40] -> SEND_JREQ, timer=0.
REQ-016 On entry to SEND_JREQ, rand_id is latched into rnd_q; tx_valid=1, header=S_JOIN_REQUEST (5), payload[63:56]=rnd_q, [55:48]=parent_id, remaining bits 0; on handshake -> WAIT_JACK, timer=0.
REQ-017 WAIT_JACK: S_JOIN_ACK (6) with payload[63:56]==rnd_q and [55:48]==parent_id latches node_id=payload[47:40], joined=1 -> JOINED; a mismatching ack is dropped.
REQ-018 tx_header/tx_payload are stable while tx_valid=1 and tx_ready=0; tx_valid never drops without a handshake except on S_RESET or rst_n.
REQ-019 Timer counts every cycle in WAIT_*; at TIMEOUT_CYCLES-1 without a matching ack: retry<MAX_RETRY -> retry+1, SEND_PREQ; otherwise -> FAILED, failed=1.
REQ-020 Matching ack and timeout in the same cycle: ack wins, no retry.
REQ-021 rx S_RESET (2) in any state -> IDLE; joined, failed, ids, timer, retry cleared; tx_valid=0 next cycle.
REQ-022 All other rx headers, and ack headers outside their wait state, are consumed and ignored.
REQ-023 Timer is wide enough for TIMEOUT_CYCLES-1 and does not wrap; retry count saturates at MAX_RETRY.

Reset
REQ-024 rst_n low asynchronously forces IDLE; tx_valid, busy, joined, failed=0; tx_header=S_NOPE (0); tx_payload, node_id, parent_id, global_id, rnd_q, timer, retry=0.
REQ-025 Reset mid-handshake abandons the flit; no partial state survives.

Configuration
REQ-026 SYSTEM_JOIN_HEARTBEAT_EN defined: in JOINED, a counter issues S_HEARTBEAT (1) with payload[63:56]=node_id and the rest 0 every HEARTBEAT_PERIOD cycles, holding it under REQ-018; counter pauses while the flit is pending.
REQ-027 SYSTEM_JOIN_HEARTBEAT_EN undefined: no heartbeat logic; tx_valid=0 in JOINED.

Verification
REQ-028 start, tx_ready=1, PARENT_ACK parent 0x12 global 0x40, rand_id=0xA5, JOIN_ACK {A5,12,07} -> JOIN_REQUEST payload[63:48]=0xA512, joined=1, node_id=0x07, parent_id=0x12, global_id=0x40.
REQ-029 tx_ready=0 for 5 cycles during SEND_PREQ -> tx_valid and header 3 held steady, single handshake, then WAIT_PACK.
REQ-030 TIMEOUT_CYCLES=8, MAX_RETRY=2, no acks -> three PARENT_REQUEST flits, failed=1 after the third timeout; start restarts.
REQ-031 JOIN_ACK with random_child_id 0xA4 (expect 0xA5), then correct ack -> first ignored, joined only after second.
REQ-032 S_RESET in WAIT_JACK, and rst_n low mid-SEND_JREQ -> IDLE, all outputs at reset values.
REQ-033 SYSTEM_JOIN_HEARTBEAT_EN, HEARTBEAT_PERIOD=16, joined node_id 0x07 -> S_HEARTBEAT payload[63:56]=0x07 every 16 cycles; none without macro.
